fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
// - Instruction-fetch control stage wrapped around the program counter register.
// - Each cycle it drives the PC's next-address input (updated_addr) and takes back the registered PC (curr_addr).
// - It issues word reads to instruction memory, holds the returned instruction for decode under a valid/ready handshake,
//   applies branch redirects and stops fetching on a halt or at the end of memory.
// - The PC has no enable; a stall is done by driving updated_addr = curr_addr.
// PARAMETERS
// - ADDR_W    32    address/instruction width
// - MEM_LAT   1     imem read latency in cycles, legal 1..4
// - MAX_ADDR  1000  last valid word address; accepting the instruction at MAX_ADDR ends fetch
// PORTS
// - clk              in   1       clock, rising edge
// - rst              in   1       reset, asynchronous, active-high
// - curr_addr        in   ADDR_W  registered PC value; reset value is all-ones
// - updated_addr     out  ADDR_W  next PC value, combinational from state + inputs
// - imem_rd_en       out  1       imem read strobe
// - imem_addr        out  ADDR_W  imem word address, = curr_addr
// - imem_rdata       in   ADDR_W  imem data, valid MEM_LAT cycles after the strobe
// - instr            out  ADDR_W  held instruction for decode
// - instr_pc         out  ADDR_W  address of instr
// - instr_valid      out  1       instr/instr_pc are valid
// - instr_ready      in   1       decode accepts; transfer = instr_valid & instr_ready
// - halt             in   1       qualifies the current transfer as a halt instruction
// - redirect_valid   in   1       branch/jump taken
// - redirect_target  in   ADDR_W  branch/jump target address
// - halted           out  1       fetch stopped
// BEHAVIOUR
// - Reset: all outputs are registered or decoded from state.
//   - state=BOOT; instr, instr_pc = 0; instr_valid, halted = 0; imem_rd_en = 0; lat_cnt = 0.
//   - Asserting rst at any time discards any in-flight read and any held instruction.
// - States: BOOT, ISSUE, WAIT, HOLD, HALTED.
// - BOOT: updated_addr = 0 (PC leaves all-ones); next state = ISSUE.
// - ISSUE:
//   - imem_rd_en = 1; updated_addr = curr_addr.
//   - lat_cnt <= MEM_LAT-1; next state = WAIT.
// - WAIT:
//   - updated_addr = curr_addr.
//   - If lat_cnt != 0: decrement lat_cnt.
//   - Else: instr <= imem_rdata; instr_pc <= curr_addr; instr_valid <= 1; next state = HOLD.
// - HOLD: instr_valid = 1.
//   - No transfer: updated_addr = curr_addr; instr and instr_pc stay stable.
//   - Transfer & halt: updated_addr = curr_addr; instr_valid <= 0; halted <= 1; next state = HALTED.
//   - Transfer & curr_addr == MAX_ADDR: same as halt (end of memory).
//   - Transfer otherwise: updated_addr = curr_addr + 1 (mod 2^ADDR_W); instr_valid <= 0; next state = ISSUE.
// - Redirect:
//   - In ISSUE, WAIT or HOLD, redirect_valid overrides everything in the same cycle:
//     updated_addr = redirect_target; instr_valid <= 0; next state = ISSUE.
//   - Any in-flight read data is dropped, and any pending transfer is ignored.
//   - The target is passed through unmodified; the PC clamps values above MAX_ADDR.
//   - Redirect is ignored in BOOT and HALTED.
// - HALTED: updated_addr = curr_addr; imem_rd_en = 0; halted = 1. Only rst exits this state.
// - Latency: strobe in cycle t; instr_valid high from cycle t+MEM_LAT+1.
//   Throughput with ready held high is 1 instruction per MEM_LAT+2 cycles.
// - imem_rd_en is high only in ISSUE, so at most one read is outstanding.
// TESTING
// - MEM_LAT=1, release rst, ready=1:
//   updated_addr=0 in BOOT; strobe at addr 0; instr_valid 3 cycles after release; instr_pc=0.
// - ready=1, imem returns addr+0x100:
//   transfers (pc,instr) = (0,0x100), (1,0x101), (2,0x102), one every 3 cycles.
// - ready=0 for 5 cycles in HOLD at pc=4:
//   instr/instr_pc stable, updated_addr=4 throughout; next transfer after ready=1 leads to fetch of 5.
// - redirect_valid with target 0x20 during WAIT at pc=7:
//   pc-7 data never appears on instr; next instr_pc=0x20.
// - halt at transfer of pc=9: halted=1, updated_addr=9, imem_rd_en=0 for 20 cycles.
//   Redirect during this window is ignored.
// - Start at MAX_ADDR-1 via redirect; accept 999 then 1000:
//   halted=1 after transfer of 1000, no fetch of 1001.
// - MEM_LAT=3: instr_valid 4 cycles after strobe.
//   rst pulsed mid-WAIT: all outputs return to reset values immediately; BOOT follows.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer around the PC register: steers the PC's next value,
// issues imem reads and holds each fetched instruction for decode under valid/ready.
module fetch_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_ADDR = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] curr_addr,
    output logic [ADDR_W-1:0] updated_addr,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted
);

    typedef enum logic [2:0] {BOOT, ISSUE, WAIT, HOLD, HALTED} state_t;

    localparam int                LAT_W     = 2;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                halted_q, halted_d;
    logic                transfer;
    logic                at_end;
    logic                redirect_live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            lat_cnt_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign transfer      = instr_valid_q & instr_ready;
    assign at_end        = (curr_addr == LAST_ADDR);
    assign redirect_live = redirect_valid &
                           ((state_q == ISSUE) | (state_q == WAIT) | (state_q == HOLD));

    // The PC has no enable, so every path that is not advancing re-drives curr_addr.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        updated_addr  = curr_addr;

        if (redirect_live) begin
            // A taken branch wins over any in-flight read and any pending transfer.
            updated_addr  = redirect_target;
            instr_valid_d = 1'b0;
            state_d       = ISSUE;
        end else begin
            case (state_q)
                BOOT: begin
                    updated_addr = '0;
                    state_d      = ISSUE;
                end
                ISSUE: begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_d = lat_cnt_q - 1'b1;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = curr_addr;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        instr_valid_d = 1'b0;
                        if (halt || at_end) begin
                            halted_d = 1'b1;
                            state_d  = HALTED;
                        end else begin
                            updated_addr = curr_addr + ADDR_W'(1);
                            state_d      = ISSUE;
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    assign imem_rd_en  = (state_q == ISSUE);
    assign imem_addr   = curr_addr;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule
